// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the unified memory arbiter
package mips_mem_pkg;

   localparam int MEM_AW = 10;
   localparam int MEM_DW = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2,
      OWN_LD   = 2'd3
   } owner_t;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating incrementer with enable, cleared only by reset
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   output logic [CW-1:0] cnt
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port arbiter sharing one memory between fetch, data and loader
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic          ld_lock,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic          ld_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          locked,
   output logic [CW-1:0] if_stall_cnt,
   output logic [CW-1:0] dm_stall_cnt
);

   arb_state_t state_q, state_d;
   owner_t     rr_ptr_q, rr_ptr_d;
   owner_t     tag_q, tag_d;
   owner_t     winner;

   // Loader lock excludes IF/DM entirely; otherwise DM first, IF/LD alternate.
   always_comb begin
      winner = OWN_NONE;
      if (state_q == ST_LOCKED) begin
         if (ld_req) winner = OWN_LD;
      end else if (dm_req) begin
         winner = OWN_DM;
      end else if (if_req && ld_req) begin
         winner = (rr_ptr_q == OWN_LD) ? OWN_LD : OWN_IF;
      end else if (if_req) begin
         winner = OWN_IF;
      end else if (ld_req) begin
         winner = OWN_LD;
      end
   end

   always_comb begin
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      ld_gnt    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (winner)
         OWN_IF: begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
         end
         OWN_DM: begin
            dm_gnt    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
         end
         OWN_LD: begin
            ld_gnt    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
         end
         default: ;
      endcase
      mem_en = if_gnt | dm_gnt | ld_gnt;
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      tag_d    = OWN_NONE;
      case (state_q)
         ST_NORMAL: if (ld_gnt && ld_lock) state_d = ST_LOCKED;
         ST_LOCKED: if (!ld_lock) state_d = ST_NORMAL;
         default:   state_d = ST_NORMAL;
      endcase
      if (if_gnt) rr_ptr_d = OWN_LD;
      if (ld_gnt) rr_ptr_d = OWN_IF;
      if (mem_en && !mem_we) tag_d = winner;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_NORMAL;
         rr_ptr_q <= OWN_IF;
         tag_q    <= OWN_NONE;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         tag_q    <= tag_d;
      end
   end

   assign locked    = (state_q == ST_LOCKED);
   assign rdata     = mem_rdata;
   assign if_rvalid = (tag_q == OWN_IF);
   assign dm_rvalid = (tag_q == OWN_DM);
   assign ld_rvalid = (tag_q == OWN_LD);

   sat_counter #(.CW(CW)) u_if_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (if_req & ~if_gnt),
      .cnt   (if_stall_cnt)
   );

   sat_counter #(.CW(CW)) u_dm_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (dm_req & ~dm_gnt),
      .cnt   (dm_stall_cnt)
   );

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed self-checking bench for mips_mem_arbiter
module tb_mips_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic          dm_req, dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt, dm_rvalid;
   logic          ld_req, ld_we, ld_lock;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata;
   logic          ld_gnt, ld_rvalid;
   logic [DW-1:0] rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          locked;
   logic [CW-1:0] if_stall_cnt, dm_stall_cnt;

   logic [DW-1:0] mem [0:1023];

   int passed = 0;
   int total  = 0;

   mips_mem_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_gnt       (if_gnt),
      .if_rvalid    (if_rvalid),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_gnt       (dm_gnt),
      .dm_rvalid    (dm_rvalid),
      .ld_req       (ld_req),
      .ld_we        (ld_we),
      .ld_lock      (ld_lock),
      .ld_addr      (ld_addr),
      .ld_wdata     (ld_wdata),
      .ld_gnt       (ld_gnt),
      .ld_rvalid    (ld_rvalid),
      .rdata        (rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .locked       (locked),
      .if_stall_cnt (if_stall_cnt),
      .dm_stall_cnt (dm_stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read memory: data appears the cycle after a read strobe.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = '0;
      dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
      ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[5]  = 32'h2800000A;
      mem[7]  = 32'h00000077;
      mem[20] = 32'hDEAD0020;
      mem_rdata = '0;

      do_reset();
      check("rst_locked", {31'b0, locked}, 0);
      check("rst_rvalids", {29'b0, if_rvalid, dm_rvalid, ld_rvalid}, 0);
      check("rst_if_cnt", {28'b0, if_stall_cnt}, 0);
      check("rst_dm_cnt", {28'b0, dm_stall_cnt}, 0);
      check("rst_mem_en", {31'b0, mem_en}, 0);

      // Single fetch
      if_req = 1; if_addr = 10'd5;
      mid();
      check("if_gnt", {31'b0, if_gnt}, 1);
      check("if_mem", {20'b0, mem_en, mem_we, mem_addr}, {20'b0, 2'b10, 10'd5});
      tick();
      if_req = 0;
      check("if_rvalid", {29'b0, if_rvalid, dm_rvalid, ld_rvalid}, 3'b100);
      check("if_rdata", rdata, 32'h2800000A);

      // DM beats IF for three cycles
      if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 10'd20;
      for (int i = 0; i < 3; i++) begin
         mid();
         check("dm_over_if_gnt", {30'b0, dm_gnt, if_gnt}, 2'b10);
         tick();
         check("dm_rvalid", {29'b0, if_rvalid, dm_rvalid, ld_rvalid}, 3'b010);
         check("dm_rdata", rdata, 32'hDEAD0020);
      end
      idle_inputs();
      check("if_stall_3", {28'b0, if_stall_cnt}, 3);
      check("dm_stall_0", {28'b0, dm_stall_cnt}, 0);

      // IF/LD round-robin starting at IF
      do_reset();
      if_req = 1; if_addr = 10'd5; ld_req = 1; ld_we = 0; ld_addr = 10'd7;
      for (int i = 0; i < 4; i++) begin
         mid();
         check("rr_gnt", {30'b0, if_gnt, ld_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
         tick();
         check("rr_rvalid", {30'b0, if_rvalid, ld_rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
         check("rr_rdata", rdata, (i % 2 == 0) ? 32'h2800000A : 32'h00000077);
      end
      idle_inputs();
      check("rr_if_stall", {28'b0, if_stall_cnt}, 2);

      // Loader lock: deferred while DM wins, then exclusive burst
      do_reset();
      dm_req = 1; dm_we = 0; dm_addr = 10'd20;
      ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 10'd0; ld_wdata = 32'h11;
      mid();
      check("lock_defer_gnt", {29'b0, dm_gnt, ld_gnt, if_gnt}, 3'b100);
      tick();
      check("lock_defer_locked", {31'b0, locked}, 0);
      check("lock_defer_rvalid", {31'b0, dm_rvalid}, 1);
      dm_req = 0;
      mid();
      check("lock_first_gnt", {30'b0, ld_gnt, mem_we}, 2'b11);
      tick();
      check("lock_locked", {31'b0, locked}, 1);
      for (int i = 1; i < 4; i++) begin
         if_req = 1; dm_req = 1;
         ld_addr = AW'(i); ld_wdata = 32'h11 * (i + 1);
         mid();
         check("lock_burst_gnt", {29'b0, ld_gnt, dm_gnt, if_gnt}, 3'b100);
         tick();
         check("lock_no_ld_rvalid", {31'b0, ld_rvalid}, 0);
      end
      ld_req = 0;
      mid();
      check("lock_idle_mem_en", {31'b0, mem_en}, 0);
      tick();
      check("lock_idle_locked", {31'b0, locked}, 1);
      ld_lock = 0;
      mid();
      check("lock_exit_dm_blocked", {31'b0, dm_gnt}, 0);
      tick();
      check("lock_exit_locked", {31'b0, locked}, 0);
      check("lock_if_stall", {28'b0, if_stall_cnt}, 5);
      check("lock_dm_stall", {28'b0, dm_stall_cnt}, 5);
      mid();
      check("unlock_dm_gnt", {31'b0, dm_gnt}, 1);
      tick();
      idle_inputs();
      for (int i = 0; i < 4; i++) check("lock_mem_write", mem[i], 32'h11 * (i + 1));

      // Saturation of dm stall counter at 15
      do_reset();
      ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 10'd100; ld_wdata = 32'h5A;
      tick();
      ld_req = 0; dm_req = 1; dm_addr = 10'd20;
      repeat (14) tick();
      check("sat_pre", {28'b0, dm_stall_cnt}, 14);
      check("sat_locked", {31'b0, locked}, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("sat_hold", {28'b0, dm_stall_cnt}, 15);
      end

      // Reset discards an in-flight fetch and restores rr_ptr
      ld_lock = 0; dm_req = 0;
      tick();
      if_req = 1; if_addr = 10'd5;
      tick();
      mid();
      check("pre_rst_if_gnt", {31'b0, if_gnt}, 1);
      rst_n = 0;
      tick();
      check("rst_flight_rvalid", {31'b0, if_rvalid}, 0);
      check("rst_flight_locked", {31'b0, locked}, 0);
      check("rst_flight_cnts", {24'b0, if_stall_cnt, dm_stall_cnt}, 0);
      rst_n = 1; if_req = 0;
      tick();
      check("post_rst_rvalid", {31'b0, if_rvalid}, 0);
      if_req = 1; ld_req = 1; ld_we = 0; ld_addr = 10'd7;
      mid();
      check("post_rst_rr", {30'b0, if_gnt, ld_gnt}, 2'b10);
      tick();
      idle_inputs();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
